// File: rtl/calc_pkg.sv
// Shared key codes, state and operator encodings for the keypad calculator datapath.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_EQ  = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;

    typedef enum logic [1:0] {
        ST_ENT_A = 2'd0,
        ST_ENT_B = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_MUL  = 2'd3
    } op_t;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/calc_mul_iter.sv
// W-cycle shift-add multiplier: start loads operands, done pulses one cycle when product is final.
module calc_mul_iter #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W) + 1;

    logic           run;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            run  <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                run <= 1'b1;
                cnt <= CW'(1);
            end else if (run) begin
                cnt <= cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // Bit 0 of the multiplier is folded into the start cycle so the last bit lands W cycles later.
    always_ff @(posedge clk) begin
        if (start) begin
            prod   <= b[0] ? {{W{1'b0}}, a} : '0;
            mcand  <= {{(W-1){1'b0}}, a, 1'b0};
            mplier <= b >> 1;
        end else if (run) begin
            prod   <= prod + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign product = prod;

endmodule

// File: rtl/calc_seq.sv
// Keypad calculator operand sequencer and arithmetic unit.
// Define CALC_SEQ_CHAIN_EN to let an operator in DONE chain the result into a new operation.
module calc_seq
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key,
    input  logic         op_a,
    input  logic         op_b,
    input  logic         op_c,
    output logic [W-1:0] disp,
    output logic         neg,
    output logic         ovf,
    output logic         result_valid,
    output logic         busy
);

    state_t         state, state_nxt;
    op_t            op, op_nxt, sel_op;
    logic [W-1:0]   opnd_a, opnd_a_nxt;
    logic [W-1:0]   opnd_b, opnd_b_nxt;
    logic [W-1:0]   disp_nxt;
    logic           neg_nxt, ovf_nxt, rv_nxt;
    logic           mul_start, mul_done;
    logic [2*W-1:0] mul_prod;
    logic           op_any, op_multi, op_one;
    logic [W:0]     add_sum;
    logic [W+3:0]   acc_val;

    // Decimal shift-in evaluated wide so an overflowing digit can be detected and dropped.
    function automatic logic [W+3:0] dec_acc(input logic [W-1:0] v, input logic [3:0] d);
        return ({4'b0, v} << 3) + ({4'b0, v} << 1) + {{W{1'b0}}, d};
    endfunction

    assign op_any   = op_a | op_b | op_c;
    assign op_multi = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
    assign op_one   = op_any & ~op_multi;
    assign sel_op   = op_a ? OP_ADD : (op_b ? OP_SUB : OP_MUL);
    assign add_sum  = {1'b0, opnd_a} + {1'b0, opnd_b};
    assign acc_val  = dec_acc((state == ST_ENT_B) ? opnd_b : opnd_a, key);

    calc_mul_iter #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (opnd_a),
        .b       (opnd_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_nxt  = state;
        op_nxt     = op;
        opnd_a_nxt = opnd_a;
        opnd_b_nxt = opnd_b;
        disp_nxt   = disp;
        neg_nxt    = neg;
        ovf_nxt    = ovf;
        rv_nxt     = 1'b0;
        mul_start  = 1'b0;
        if (state == ST_MUL) begin
            if (mul_done) begin
                disp_nxt  = mul_prod[W-1:0];
                ovf_nxt   = |mul_prod[2*W-1:W];
                rv_nxt    = 1'b1;
                state_nxt = ST_DONE;
            end
        end else if (key_valid && !op_multi) begin
            if (op_one) begin
                case (state)
                    ST_ENT_A: begin
                        op_nxt     = sel_op;
                        opnd_b_nxt = '0;
                        disp_nxt   = '0;
                        state_nxt  = ST_ENT_B;
                    end
                    ST_ENT_B: op_nxt = sel_op;
`ifdef CALC_SEQ_CHAIN_EN
                    ST_DONE: begin
                        if (!neg) begin
                            opnd_a_nxt = disp;
                            op_nxt     = sel_op;
                            opnd_b_nxt = '0;
                            disp_nxt   = '0;
                            ovf_nxt    = 1'b0;
                            state_nxt  = ST_ENT_B;
                        end
                    end
`endif
                    default: ;
                endcase
            end else if (key == KEY_CLR) begin
                state_nxt  = ST_ENT_A;
                op_nxt     = OP_NONE;
                opnd_a_nxt = '0;
                opnd_b_nxt = '0;
                disp_nxt   = '0;
                neg_nxt    = 1'b0;
                ovf_nxt    = 1'b0;
            end else if (is_digit(key)) begin
                if (state == ST_DONE) begin
                    opnd_a_nxt = {{(W-4){1'b0}}, key};
                    opnd_b_nxt = '0;
                    op_nxt     = OP_NONE;
                    disp_nxt   = {{(W-4){1'b0}}, key};
                    neg_nxt    = 1'b0;
                    ovf_nxt    = 1'b0;
                    state_nxt  = ST_ENT_A;
                end else if (acc_val[W+3:W] == 4'd0) begin
                    disp_nxt = acc_val[W-1:0];
                    if (state == ST_ENT_B) opnd_b_nxt = acc_val[W-1:0];
                    else                   opnd_a_nxt = acc_val[W-1:0];
                end
            end else if (key == KEY_EQ && state == ST_ENT_B) begin
                case (op)
                    OP_ADD: begin
                        disp_nxt  = add_sum[W-1:0];
                        ovf_nxt   = add_sum[W];
                        neg_nxt   = 1'b0;
                        rv_nxt    = 1'b1;
                        state_nxt = ST_DONE;
                    end
                    OP_SUB: begin
                        disp_nxt  = (opnd_a >= opnd_b) ? opnd_a - opnd_b : opnd_b - opnd_a;
                        neg_nxt   = (opnd_a < opnd_b);
                        ovf_nxt   = 1'b0;
                        rv_nxt    = 1'b1;
                        state_nxt = ST_DONE;
                    end
                    OP_MUL: begin
                        mul_start = 1'b1;
                        state_nxt = ST_MUL;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_ENT_A;
            op           <= OP_NONE;
            opnd_a       <= '0;
            opnd_b       <= '0;
            disp         <= '0;
            neg          <= 1'b0;
            ovf          <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            op           <= op_nxt;
            opnd_a       <= opnd_a_nxt;
            opnd_b       <= opnd_b_nxt;
            disp         <= disp_nxt;
            neg          <= neg_nxt;
            ovf          <= ovf_nxt;
            result_valid <= rv_nxt;
        end
    end

    assign busy = (state == ST_MUL);

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq: directed test-plan sequences plus random keys against a reference model.
module tb_calc_seq;
    import calc_pkg::*;

    localparam int W = 16;
    localparam longint MAXV = (64'd1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [3:0]   key = 4'h0;
    logic         op_a = 1'b0, op_b = 1'b0, op_c = 1'b0;
    logic [W-1:0] disp;
    logic         neg, ovf, result_valid, busy;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: 0 entering A, 1 entering B, 2 showing a result
    int         m_mode;
    longint     ma, mb, mdisp;
    logic [3:0] mop;
    bit         mneg, movf;

    calc_seq #(.W(W)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key(key),
        .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .disp(disp), .neg(neg), .ovf(ovf),
        .result_valid(result_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode = 0; ma = 0; mb = 0; mdisp = 0; mop = 4'h0; mneg = 0; movf = 0;
    endtask

    task automatic model_key(input logic [3:0] k, output bit rv_e, output bit mul_e);
        longint t;
        rv_e = 0; mul_e = 0;
        if (k == KEY_ADD || k == KEY_SUB || k == KEY_MUL) begin
            if (m_mode == 0) begin
                mop = k; mb = 0; mdisp = 0; m_mode = 1;
            end else if (m_mode == 1) begin
                mop = k;
            end else begin
`ifdef CALC_SEQ_CHAIN_EN
                if (!mneg) begin
                    ma = mdisp; mop = k; mb = 0; mdisp = 0; movf = 0; m_mode = 1;
                end
`endif
            end
        end else if (k == KEY_CLR) begin
            model_reset();
        end else if (k <= 4'd9) begin
            if (m_mode == 2) begin
                ma = k; mb = 0; mdisp = k; mneg = 0; movf = 0; m_mode = 0;
            end else begin
                t = ((m_mode == 1) ? mb : ma) * 10 + k;
                if (t <= MAXV) begin
                    if (m_mode == 1) mb = t; else ma = t;
                    mdisp = t;
                end
            end
        end else if (k == KEY_EQ && m_mode == 1) begin
            if (mop == KEY_ADD) begin
                t = ma + mb; mdisp = t & MAXV; movf = (t > MAXV); mneg = 0;
            end else if (mop == KEY_SUB) begin
                mneg = (ma < mb); mdisp = mneg ? mb - ma : ma - mb; movf = 0;
            end else begin
                t = ma * mb; mdisp = t & MAXV; movf = (t > MAXV); mneg = 0; mul_e = 1;
            end
            rv_e = !mul_e;
            m_mode = 2;
        end
    endtask

    task automatic press(input logic [3:0] k, input bit inject);
        bit rv_e, mul_e;
        key = k; key_valid = 1'b1;
        op_a = (k == KEY_ADD); op_b = (k == KEY_SUB); op_c = (k == KEY_MUL);
        @(posedge clk); #1;
        key_valid = 1'b0; op_a = 1'b0; op_b = 1'b0; op_c = 1'b0;
        model_key(k, rv_e, mul_e);
        if (!mul_e) begin
            chk("disp", disp, mdisp);
            chk("neg", neg, mneg);
            chk("ovf", ovf, movf);
            chk("result_valid", result_valid, rv_e);
            chk("busy_idle", busy, 0);
        end else begin
            chk("busy_start", busy, 1);
            chk("rv_early", result_valid, 0);
            if (inject) begin key = KEY_CLR; key_valid = 1'b1; end
            for (int i = 1; i < W; i++) begin
                @(posedge clk); #1;
                key_valid = 1'b0;
                chk("busy_hold", busy, 1);
                chk("rv_during_mul", result_valid, 0);
            end
            @(posedge clk); #1;
            chk("busy_end", busy, 0);
            chk("rv_mul", result_valid, 1);
            chk("disp_mul", disp, mdisp);
            chk("ovf_mul", ovf, movf);
            chk("neg_mul", neg, 0);
        end
    endtask

    task automatic seq(input logic [3:0] ks[$]);
        foreach (ks[i]) press(ks[i], 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_disp"}, disp, 0);
        chk({tag, "_neg"}, neg, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [3:0] k;
        int r;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Add: 12 + 34
        seq('{4'd1, 4'd2, KEY_ADD, 4'd3, 4'd4, KEY_EQ});
        chk("add46", disp, 46);
        // Sub with negative result: 5 - 12
        seq('{4'd5, KEY_SUB, 4'd1, 4'd2, KEY_EQ});
        chk("sub_mag", disp, 7);
        chk("sub_neg", neg, 1);
        // Multiply 255*257 then 256*256, with a clear injected while busy on the first
        press(4'd2, 0); press(4'd5, 0); press(4'd5, 0); press(KEY_MUL, 0);
        press(4'd2, 0); press(4'd5, 0); press(4'd7, 0); press(KEY_EQ, 1);
        chk("mul_max", disp, 65535);
        seq('{4'd2, 4'd5, 4'd6, KEY_MUL, 4'd2, 4'd5, 4'd6, KEY_EQ});
        chk("mul_ovf_disp", disp, 0);
        chk("mul_ovf", ovf, 1);
        // Digit overflow drop, then add overflow
        seq('{KEY_CLR, 4'd6, 4'd5, 4'd5, 4'd3, 4'd5, 4'd9});
        chk("digit_drop", disp, 65535);
        seq('{KEY_CLR, 4'd6, 4'd5, 4'd5, 4'd3, 4'd5, KEY_ADD, 4'd1, KEY_EQ});
        chk("add_ovf_disp", disp, 0);
        chk("add_ovf", ovf, 1);
        // Clear mid-entry, unknown code, equals in ENT_A, multi-select ignored
        seq('{4'd4, KEY_ADD, 4'd9, KEY_CLR});
        check_zero("clear");
        seq('{4'd8, 4'hF, KEY_EQ});
        chk("ignored_keys", disp, 8);
        key = KEY_ADD; key_valid = 1'b1; op_a = 1'b1; op_b = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0; op_a = 1'b0; op_b = 1'b0;
        chk("multi_sel", disp, 8);
        press(4'd1, 0);
        chk("multi_sel_state", disp, 81);
        // Chain / no-chain behaviour
        seq('{KEY_CLR, 4'd3, KEY_ADD, 4'd4, KEY_EQ, KEY_MUL, 4'd5, KEY_EQ});
`ifdef CALC_SEQ_CHAIN_EN
        chk("chain", disp, 35);
`else
        chk("no_chain", disp, 5);
`endif
        // Reset aborts multiply; reset wins over a simultaneous key
        seq('{KEY_CLR, 4'd9, KEY_MUL, 4'd9});
        key = KEY_EQ; op_c = 1'b0; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        chk("mul_busy", busy, 1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; key = 4'd3; key_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; key_valid = 1'b0;
        model_reset();
        check_zero("rst_mul");
        press(4'd7, 0);
        chk("fresh_digit", disp, 7);

        // Random key stream against the model
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      k = 4'($urandom_range(0, 9));
            else if (r < 72) k = 4'($urandom_range(10, 12));
            else if (r < 86) k = KEY_EQ;
            else if (r < 90) k = KEY_CLR;
            else if (r < 93) k = 4'hF;
            else             k = 4'($urandom_range(0, 2));
            press(k, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
